// File: rtl/axis_if_pkg.sv
// Shared definitions for the AXI4-Stream input buffer: entry field
// layout helpers and register-slice state encoding.
package axis_if_pkg;

    localparam logic [1:0] SL_ZERO_ENC = 2'd0;
    localparam logic [1:0] SL_ONE_ENC  = 2'd1;
    localparam logic [1:0] SL_TWO_ENC  = 2'd2;

    typedef enum logic [1:0] {
        SL_ZERO = SL_ZERO_ENC,
        SL_ONE  = SL_ONE_ENC,
        SL_TWO  = SL_TWO_ENC
    } slice_state_e;

    // Entry packing is {TUSER, TLAST, TKEEP, TDATA}, LSB first from TDATA.
    function automatic int ent_width(input int tbits, input int tbyte);
        return tbits + tbyte + 2;
    endfunction

    function automatic int keep_pos(input int tbits);
        return tbits;
    endfunction

    function automatic int last_pos(input int tbits, input int tbyte);
        return tbits + tbyte;
    endfunction

    function automatic int user_pos(input int tbits, input int tbyte);
        return tbits + tbyte + 1;
    endfunction

endpackage

// File: rtl/axis_circ_fifo.sv
// Circular-pointer FIFO with first-word-fall-through read port.
// Pointers carry one extra wrap bit to tell full from empty.
module axis_circ_fifo
    import axis_if_pkg::*;
#(
    parameter int WIDTH      = 38,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level,
    output logic                  wr_ack,
    output logic                  rd_ack
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] PTR_ONE = 1;

    logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    always_comb begin
        full   = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                 (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
        empty  = (wr_ptr_q == rd_ptr_q);
        wr_ack = wr_en & ~full;
        rd_ack = rd_en & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ack) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ack) rd_ptr_d = rd_ptr_q + PTR_ONE;
        level   = wr_ptr_q - rd_ptr_q;
        rd_data = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ack) mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_input_stream_buf.sv
// AXI4-Stream slave input buffer: optional skid slice, circular FIFO,
// fill/packet reporting and optional store-and-forward head gating.
module axis_input_stream_buf
    import axis_if_pkg::*;
#(
    parameter int TBITS      = 32,
    parameter int TBYTE      = TBITS / 8,
    parameter int DEPTH_BITS = 4,
    parameter int REG_SLICE  = 1,
    parameter int PKT_MODE   = 0,
    parameter int AF_LEVEL   = 2 ** DEPTH_BITS - 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  TVALID,
    output logic                  TREADY,
    input  logic [TBITS-1:0]      TDATA,
    input  logic [TBYTE-1:0]      TKEEP,
    input  logic                  TLAST,
    input  logic                  TUSER,
    output logic [TBITS-1:0]      isif_data_dout,
    output logic [TBYTE-1:0]      isif_strb_dout,
    output logic                  isif_last_dout,
    output logic                  isif_user_dout,
    output logic                  isif_empty_n,
    input  logic                  isif_read,
    output logic [DEPTH_BITS:0]   isif_level,
    output logic                  isif_almost_full,
    output logic [DEPTH_BITS:0]   isif_pkt_cnt
);

    localparam int EW     = ent_width(TBITS, TBYTE);
    localparam int KEEP_B = keep_pos(TBITS);
    localparam int LAST_B = last_pos(TBITS, TBYTE);
    localparam int USER_B = user_pos(TBITS, TBYTE);
    localparam logic [DEPTH_BITS:0] AF_L    = (DEPTH_BITS + 1)'(AF_LEVEL);
    localparam logic [DEPTH_BITS:0] CNT_ONE = 1;

    logic [EW-1:0]       s_ent;
    logic [EW-1:0]       m_data;
    logic [EW-1:0]       f_dout;
    logic                m_valid;
    logic                f_full;
    logic                f_empty;
    logic                f_wr_ack;
    logic                f_rd_ack;
    logic                f_rd_en;
    logic [DEPTH_BITS:0] f_level;
    logic [DEPTH_BITS:0] pkt_q, pkt_d;
    logic                rel_q, rel_d;
    logic                wr_last;
    logic                rd_last;
    logic                head_ok;

    assign s_ent = {TUSER, TLAST, TKEEP, TDATA};

    generate
        if (REG_SLICE != 0) begin : g_slice
            slice_state_e  st_q, st_d;
            logic [EW-1:0] r0_q, r0_d;
            logic [EW-1:0] r1_q, r1_d;
            logic          rdy_q, rdy_d;
            logic          acc;

            // r0 is always the beat offered to the FIFO; r1 is the skid.
            always_comb begin
                st_d = st_q;
                r0_d = r0_q;
                r1_d = r1_q;
                acc  = TVALID & rdy_q;
                unique case (st_q)
                    SL_ZERO: begin
                        if (acc) begin
                            st_d = SL_ONE;
                            r0_d = s_ent;
                        end
                    end
                    SL_ONE: begin
                        if (acc && f_wr_ack) begin
                            r0_d = s_ent;
                        end else if (acc) begin
                            st_d = SL_TWO;
                            r1_d = s_ent;
                        end else if (f_wr_ack) begin
                            st_d = SL_ZERO;
                        end
                    end
                    SL_TWO: begin
                        if (f_wr_ack) begin
                            st_d = SL_ONE;
                            r0_d = r1_q;
                        end
                    end
                    default: st_d = SL_ZERO;
                endcase
                rdy_d = (st_d != SL_TWO);
            end

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    st_q  <= SL_ZERO;
                    r0_q  <= '0;
                    r1_q  <= '0;
                    rdy_q <= 1'b0;
                end else begin
                    st_q  <= st_d;
                    r0_q  <= r0_d;
                    r1_q  <= r1_d;
                    rdy_q <= rdy_d;
                end
            end

            assign m_valid = (st_q != SL_ZERO);
            assign m_data  = r0_q;
            assign TREADY  = rdy_q;
        end else begin : g_direct
            logic arm_q, arm_d;

            // Holds TREADY low until the first edge after reset release.
            assign arm_d = 1'b1;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) arm_q <= 1'b0;
                else          arm_q <= arm_d;
            end

            assign TREADY  = arm_q & ~f_full;
            assign m_valid = TVALID & TREADY;
            assign m_data  = s_ent;
        end
    endgenerate

    axis_circ_fifo #(
        .WIDTH      (EW),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .wr_en   (m_valid),
        .wr_data (m_data),
        .rd_en   (f_rd_en),
        .rd_data (f_dout),
        .full    (f_full),
        .empty   (f_empty),
        .level   (f_level),
        .wr_ack  (f_wr_ack),
        .rd_ack  (f_rd_ack)
    );

    assign head_ok      = (PKT_MODE == 0) || (pkt_q != '0) || rel_q;
    assign isif_empty_n = ~f_empty & head_ok;
    assign f_rd_en      = isif_read & isif_empty_n;

    always_comb begin
        wr_last = f_wr_ack & m_data[LAST_B];
        rd_last = f_rd_ack & f_dout[LAST_B];
        pkt_d   = pkt_q;
        if (wr_last && !rd_last)      pkt_d = pkt_q + CNT_ONE;
        else if (!wr_last && rd_last) pkt_d = pkt_q - CNT_ONE;
        // Release lets an oversized packet drain instead of deadlocking.
        rel_d = rel_q;
        if (PKT_MODE == 0)                 rel_d = 1'b0;
        else if (rd_last)                  rel_d = 1'b0;
        else if (f_full && pkt_q == '0)    rel_d = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pkt_q <= '0;
            rel_q <= 1'b0;
        end else begin
            pkt_q <= pkt_d;
            rel_q <= rel_d;
        end
    end

    assign isif_data_dout   = f_dout[TBITS-1:0];
    assign isif_strb_dout   = f_dout[KEEP_B +: TBYTE];
    assign isif_last_dout   = f_dout[LAST_B];
    assign isif_user_dout   = f_dout[USER_B];
    assign isif_level       = f_level;
    assign isif_almost_full = (f_level >= AF_L);
    assign isif_pkt_cnt     = pkt_q;

endmodule

// File: tb/tb_axis_input_stream_buf.sv
// Self-checking bench: three buffer variants (slice, no slice,
// store-and-forward) checked against vectors and a scoreboard queue.
module tb_axis_input_stream_buf;

    typedef logic [37:0] ent_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        r;
        logic        exp_rdy;
        logic        exp_en;
        int          exp_lvl;
        int          exp_pkt;
        logic [31:0] exp_head;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic        tvalid [3];
    logic        tready [3];
    logic [31:0] tdata  [3];
    logic [3:0]  tkeep  [3];
    logic        tlast  [3];
    logic        tuser  [3];
    logic [31:0] odata  [3];
    logic [3:0]  ostrb  [3];
    logic        olast  [3];
    logic        ouser  [3];
    logic        en     [3];
    logic        rd     [3];
    logic [4:0]  lvl    [3];
    logic        af     [3];
    logic [4:0]  pkt    [3];

    ent_t sbq[$];
    int   q_last;
    int   nvec;
    int   nerr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_input_stream_buf #(
            .TBITS      (32),
            .TBYTE      (4),
            .DEPTH_BITS (4),
            .REG_SLICE  ((g == 1) ? 0 : 1),
            .PKT_MODE   ((g == 2) ? 1 : 0),
            .AF_LEVEL   (14)
        ) u_dut (
            .ACLK             (clk),
            .ARESETN          (rst_n),
            .TVALID           (tvalid[g]),
            .TREADY           (tready[g]),
            .TDATA            (tdata[g]),
            .TKEEP            (tkeep[g]),
            .TLAST            (tlast[g]),
            .TUSER            (tuser[g]),
            .isif_data_dout   (odata[g]),
            .isif_strb_dout   (ostrb[g]),
            .isif_last_dout   (olast[g]),
            .isif_user_dout   (ouser[g]),
            .isif_empty_n     (en[g]),
            .isif_read        (rd[g]),
            .isif_level       (lvl[g]),
            .isif_almost_full (af[g]),
            .isif_pkt_cnt     (pkt[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] d, input logic l);
        return {1'b0, l, 4'hF, d};
    endfunction

    // One clock for instance k; scoreboard push on accept, compare on pop.
    task automatic cyc(input int k, input logic v, input ent_t e,
                       input logic r, output logic acc, output logic pop);
        ent_t h;
        tvalid[k] = v;
        {tuser[k], tlast[k], tkeep[k], tdata[k]} = e;
        rd[k] = r;
        acc = v & tready[k];
        pop = r & en[k];
        if (pop) begin
            h = {ouser[k], olast[k], ostrb[k], odata[k]};
            if (sbq.size() == 0) begin
                chk("pop_with_empty_sb", 64'(en[k]), 64'd0);
            end else begin
                chk("pop_data", 64'(h), 64'(sbq[0]));
                if (sbq[0][36]) q_last--;
                void'(sbq.pop_front());
            end
        end
        if (acc) begin
            sbq.push_back(e);
            if (e[36]) q_last++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v0);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tvalid[k] = 1'b0;
            rd[k]     = 1'b0;
            tdata[k]  = 32'hA5A5A5A5;
            tkeep[k]  = 4'hF;
            tlast[k]  = 1'b0;
            tuser[k]  = 1'b0;
        end
        tvalid[0] = v0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_tready", 64'(tready[k]), 64'd0);
            chk("rst_empty_n", 64'(en[k]), 64'd0);
            chk("rst_level", 64'(lvl[k]), 64'd0);
            chk("rst_pkt_cnt", 64'(pkt[k]), 64'd0);
            chk("rst_almost_full", 64'(af[k]), 64'd0);
        end
        sbq.delete();
        q_last = 0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int k);
        logic a, p;
        for (int c = 0; c < 200 && sbq.size() != 0; c++)
            cyc(k, 1'b0, '0, 1'b1, a, p);
        cyc(k, 1'b0, '0, 1'b0, a, p);
        chk("drain_sb_empty", 64'(sbq.size()), 64'd0);
        chk("drain_level", 64'(lvl[k]), 64'd0);
        chk("drain_pkt_cnt", 64'(pkt[k]), 64'd0);
        chk("drain_empty_n", 64'(en[k]), 64'd0);
    endtask

    task automatic rnd(input int k, input int n, input logic model);
        logic a, p, v, r, lb;
        ent_t e;
        int   sent;
        sent = 0;
        for (int c = 0; c < 60000 && sent < n; c++) begin
            v  = ($urandom_range(3) != 0);
            r  = ($urandom_range(3) != 0);
            lb = (sent == n - 1) ? 1'b1 : ($urandom_range(7) == 0);
            e  = {1'($urandom_range(1)), lb, 4'($urandom_range(15)),
                  32'($urandom)};
            if (model) begin
                chk("rnd_level", 64'(lvl[k]), 64'(sbq.size()));
                chk("rnd_pkt_cnt", 64'(pkt[k]), 64'(q_last));
            end
            cyc(k, v, e, r, a, p);
            if (a) sent++;
        end
        chk("rnd_sent", 64'(sent), 64'(n));
        drain(k);
    endtask

    initial begin
        vec_t tbl [9];
        logic a, p, seen;
        int   i, ex;
        nvec = 0;
        nerr = 0;
        q_last = 0;

        tbl[0] = '{1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 32'h0};
        tbl[1] = '{1, 32'hA5A5A5A5, 0, 0, 1, 0, 0, 0, 32'h0};
        tbl[2] = '{0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0};
        tbl[3] = '{1, 32'h11,       0, 1, 1, 1, 1, 0, 32'hA5A5A5A5};
        tbl[4] = '{1, 32'h22,       1, 0, 1, 0, 0, 0, 32'h0};
        tbl[5] = '{0, 32'h0,        0, 0, 1, 1, 1, 0, 32'h11};
        tbl[6] = '{0, 32'h0,        0, 1, 1, 1, 2, 1, 32'h11};
        tbl[7] = '{0, 32'h0,        0, 1, 1, 1, 1, 1, 32'h22};
        tbl[8] = '{0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0};

        // Reset held with TVALID high, then the vector table.
        do_reset(1'b1);
        for (int n = 0; n < 9; n++) begin
            chk("tbl_tready", 64'(tready[0]), 64'(tbl[n].exp_rdy));
            chk("tbl_empty_n", 64'(en[0]), 64'(tbl[n].exp_en));
            chk("tbl_level", 64'(lvl[0]), 64'(tbl[n].exp_lvl));
            chk("tbl_pkt_cnt", 64'(pkt[0]), 64'(tbl[n].exp_pkt));
            if (tbl[n].exp_en)
                chk("tbl_head", 64'(odata[0]), 64'(tbl[n].exp_head));
            cyc(0, tbl[n].v, mk(tbl[n].d, tbl[n].l), tbl[n].r, a, p);
        end

        // Fill: 16 in FIFO plus 2 in slice, then ordered drain.
        do_reset(1'b0);
        cyc(0, 1'b0, '0, 1'b0, a, p);
        i = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(0, 1'b1, mk(32'(i), 1'b0), 1'b0, a, p);
            if (a) i++;
        end
        chk("fill_accepted", 64'(i), 64'd18);
        chk("fill_tready", 64'(tready[0]), 64'd0);
        chk("fill_level", 64'(lvl[0]), 64'd16);
        chk("fill_almost_full", 64'(af[0]), 64'd1);
        for (int c = 0; c < 18; c++) begin
            ex = (c == 0) ? 16 : (c <= 3) ? 15 : 18 - c;
            chk("unfill_level", 64'(lvl[0]), 64'(ex));
            chk("unfill_almost_full", 64'(af[0]), 64'(ex >= 14));
            chk("unfill_empty_n", 64'(en[0]), 64'd1);
            cyc(0, 1'b0, '0, 1'b1, a, p);
        end
        drain(0);

        // Streaming: one beat per cycle at constant level 1.
        do_reset(1'b0);
        cyc(0, 1'b0, '0, 1'b0, a, p);
        for (int c = 0; c < 24; c++) begin
            if (c >= 2) chk("stream_level", 64'(lvl[0]), 64'd1);
            cyc(0, 1'b1, mk(32'(100 + c), 1'b0), 1'b1, a, p);
            chk("stream_accept", 64'(a), 64'd1);
            if (c >= 2) chk("stream_pop", 64'(p), 64'd1);
        end
        drain(0);

        // No slice: beat visible right after its accepting edge.
        do_reset(1'b0);
        chk("noslice_rdy_low", 64'(tready[1]), 64'd0);
        cyc(1, 1'b1, mk(32'hCAFE, 1'b1), 1'b0, a, p);
        chk("noslice_rdy_high", 64'(tready[1]), 64'd1);
        cyc(1, 1'b1, mk(32'hCAFE, 1'b1), 1'b0, a, p);
        chk("noslice_empty_n", 64'(en[1]), 64'd1);
        chk("noslice_head", 64'(odata[1]), 64'h0000_CAFE);
        chk("noslice_pkt_cnt", 64'(pkt[1]), 64'd1);
        drain(1);
        i = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1, 1'b1, mk(32'(c), 1'b0), 1'b0, a, p);
            if (a) i++;
        end
        chk("noslice_fill", 64'(i), 64'd16);
        chk("noslice_full_rdy", 64'(tready[1]), 64'd0);
        drain(1);

        // Store-and-forward: gapped 3-beat packet.
        do_reset(1'b0);
        cyc(2, 1'b0, '0, 1'b0, a, p);
        for (int b = 0; b < 3; b++) begin
            cyc(2, 1'b1, mk(32'(200 + b), b == 2), 1'b0, a, p);
            chk("pkt_accept", 64'(a), 64'd1);
            for (int g = 0; g < ((b == 2) ? 1 : 5); g++)
                cyc(2, 1'b0, '0, 1'b0, a, p);
            if (b < 2) begin
                chk("pkt_gated", 64'(en[2]), 64'd0);
                chk("pkt_level", 64'(lvl[2]), 64'(b + 1));
            end
        end
        chk("pkt_open", 64'(en[2]), 64'd1);
        chk("pkt_cnt_one", 64'(pkt[2]), 64'd1);
        chk("pkt_level3", 64'(lvl[2]), 64'd3);
        cyc(2, 1'b0, '0, 1'b1, a, p);
        cyc(2, 1'b0, '0, 1'b1, a, p);
        chk("pkt_mid_cnt", 64'(pkt[2]), 64'd1);
        drain(2);

        // Store-and-forward: oversized packet forces release.
        do_reset(1'b0);
        cyc(2, 1'b0, '0, 1'b0, a, p);
        i = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !(i == 20 && sbq.size() == 0); c++) begin
            ex = int'(lvl[2]);
            cyc(2, i < 20, mk(32'(500 + i), i == 19), 1'b1, a, p);
            if (a) i++;
            if (p && !seen) begin
                seen = 1'b1;
                chk("big_first_pop_level", 64'(ex), 64'd16);
            end
        end
        chk("big_sent", 64'(i), 64'd20);
        chk("big_done", 64'(sbq.size()), 64'd0);
        cyc(2, 1'b1, mk(32'h77, 1'b0), 1'b0, a, p);
        repeat (3) cyc(2, 1'b0, '0, 1'b0, a, p);
        chk("big_release_cleared", 64'(en[2]), 64'd0);
        chk("big_partial_level", 64'(lvl[2]), 64'd1);

        // Random traffic on all variants.
        do_reset(1'b0);
        rnd(0, 10000, 1'b0);
        do_reset(1'b0);
        rnd(1, 10000, 1'b1);
        do_reset(1'b0);
        rnd(2, 3000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
